// File: rtl/mesh_sort_demo.sv
// Demonstration mesh: loads a reverse-permutation packet set and shearsorts it by address.
// Optional MESH_DB_ADDR_OUT_EN exposes the address field on nanci_result as well as the data.
module mesh_sort_demo #(
    parameter int unsigned N           = 16,
    parameter int unsigned SQRT_N      = 4,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 6,
    parameter int unsigned SORT_CYCLES = 21,
    localparam int unsigned WIDTH      = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] nanci_result [N]
);

    localparam int unsigned LOG_S = $clog2(SQRT_N);
    localparam int unsigned CNT_W = $clog2(SORT_CYCLES + 1);

    logic [WIDTH-1:0] pkt     [N];
    logic [WIDTH-1:0] nxt_pkt [N];
    logic [CNT_W-1:0] cnt;
    logic             done;

    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] phase;
    logic             loading;
    logic             active;
    logic             last_step;
    logic             is_row_ph;
    logic             is_final;
    logic             s_par;

    // Step decode: cnt 0 is the load edge, cnt k>0 performs global step k-1.
    always_comb begin
        step      = cnt - CNT_W'(1);
        phase     = step >> LOG_S;
        loading   = (cnt == '0);
        active    = !loading && !done;
        last_step = active && (cnt == CNT_W'(SORT_CYCLES - 1));
        is_final  = (phase == CNT_W'(2 * LOG_S));
        is_row_ph = !phase[0];
        s_par     = step[0];
    end

    for (genvar i = 0; i < N; i++) begin : g_pe
        localparam int unsigned ROW       = i / SQRT_N;
        localparam int unsigned COL       = i % SQRT_N;
        localparam logic        ROW_ODD   = 1'(ROW % 2);
        localparam logic        COL_ODD   = 1'(COL % 2);
        localparam logic        HAS_R     = (COL + 1 < SQRT_N);
        localparam logic        HAS_L     = (COL > 0);
        localparam logic        HAS_D     = (ROW + 1 < SQRT_N);
        localparam logic        HAS_U     = (ROW > 0);
        localparam int unsigned R_IDX     = HAS_R ? i + 1 : i;
        localparam int unsigned L_IDX     = HAS_L ? i - 1 : i;
        localparam int unsigned D_IDX     = HAS_D ? i + SQRT_N : i;
        localparam int unsigned U_IDX     = HAS_U ? i - SQRT_N : i;
        localparam int unsigned LOAD_ADDR = N - 1 - i;
        localparam int unsigned LOAD_DATA =
            (3 + (LOAD_ADDR % SQRT_N) + 2 * (LOAD_ADDR / SQRT_N)) % (2 ** DATA_WIDTH);
        localparam logic [WIDTH-1:0] LOAD_PKT =
            {ADDR_WIDTH'(LOAD_ADDR), DATA_WIDTH'(LOAD_DATA)};

        logic [WIDTH-1:0]      part;
        logic                  valid;
        logic                  is_lo;
        logic                  asc;
        logic                  swap;
        logic [ADDR_WIDTH-1:0] own_key;
        logic [ADDR_WIDTH-1:0] part_key;

        // Pair selection: the lower element of a pair keeps the min (ascending) or max (descending).
        always_comb begin
            part  = pkt[i];
            valid = 1'b0;
            is_lo = 1'b0;
            asc   = 1'b1;
            if (is_row_ph) begin
                is_lo = (COL_ODD == s_par);
                asc   = is_final || !ROW_ODD;
                if (is_lo && HAS_R) begin
                    part  = pkt[R_IDX];
                    valid = 1'b1;
                end else if (!is_lo && HAS_L) begin
                    part  = pkt[L_IDX];
                    valid = 1'b1;
                end
            end else begin
                is_lo = (ROW_ODD == s_par);
                if (is_lo && HAS_D) begin
                    part  = pkt[D_IDX];
                    valid = 1'b1;
                end else if (!is_lo && HAS_U) begin
                    part  = pkt[U_IDX];
                    valid = 1'b1;
                end
            end
            own_key  = pkt[i][WIDTH-1 -: ADDR_WIDTH];
            part_key = part[WIDTH-1 -: ADDR_WIDTH];
            if (is_lo == asc) begin
                swap = valid && (own_key > part_key);
            end else begin
                swap = valid && (own_key < part_key);
            end
            if (loading) begin
                nxt_pkt[i] = LOAD_PKT;
            end else if (active && swap) begin
                nxt_pkt[i] = part;
            end else begin
                nxt_pkt[i] = pkt[i];
            end
        end
    end

    // Packet registers, step counter and done flag; everything freezes once done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                pkt[i] <= '0;
            end
            cnt  <= '0;
            done <= 1'b0;
        end else if (!done) begin
            pkt <= nxt_pkt;
            cnt <= cnt + CNT_W'(1);
            if (last_step) begin
                done <= 1'b1;
            end
        end
    end

    // Result capture from the post-step packets so results appear on the done edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                nanci_result[i] <= '0;
            end
        end else if (last_step) begin
            for (int i = 0; i < N; i++) begin
`ifdef MESH_DB_ADDR_OUT_EN
                nanci_result[i] <= nxt_pkt[i];
`else
                nanci_result[i] <= {ADDR_WIDTH'(0), nxt_pkt[i][DATA_WIDTH-1:0]};
`endif
            end
        end
    end

endmodule

// File: tb/tb_mesh_sort_demo.sv
// Self-checking bench for mesh_sort_demo: scoreboard of expected per-PE results, zero checks before done.
// Honours MESH_DB_ADDR_OUT_EN in its expected-value model.
module tb_mesh_sort_demo;

    localparam int unsigned N  = 16;
    localparam int unsigned S  = 4;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 6;
    localparam int unsigned SC = 21;
    localparam int unsigned W  = AW + DW;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] res [N];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb [$];

    mesh_sort_demo #(
        .N(N), .SQRT_N(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SORT_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .nanci_result(res)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(int i);
        logic [DW-1:0] d;
        d = DW'(3 + (i % S) + 2 * (i / S));
`ifdef MESH_DB_ADDR_OUT_EN
        return {AW'(i), d};
`else
        return {AW'(0), d};
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res[i] !== '0) begin
                errors++;
                $display("FAIL reset_zero pe=%0d got=%h exp=0", i, res[i]);
            end
        end
    endtask

    // Release reset, expect zeros for SC-1 edges, then the sorted result exactly on edge SC.
    task automatic test_sort(string tag);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) sb.push_back(model(i));
        for (int k = 1; k < SC; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                checks++;
                if (res[i] !== '0) begin
                    errors++;
                    $display("FAIL %s early_zero edge=%0d pe=%0d got=%h exp=0", tag, k, i, res[i]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] exp_v;
            exp_v = sb.pop_front();
            checks++;
            if (res[i] !== exp_v) begin
                errors++;
                $display("FAIL %s result pe=%0d got=%h exp=%h", tag, i, res[i], exp_v);
            end
        end
    endtask

    task automatic test_spot_values();
        logic [DW-1:0] exp_d [4];
        int            pe    [4];
        pe = '{0, 3, 12, 15};
        exp_d = '{6'd3, 6'd6, 6'd9, 6'd12};
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (res[pe[j]][DW-1:0] !== exp_d[j]) begin
                errors++;
                $display("FAIL spot_data pe=%0d got=%h exp=%h", pe[j], res[pe[j]][DW-1:0], exp_d[j]);
            end
        end
`ifdef MESH_DB_ADDR_OUT_EN
        checks++;
        if (res[5] !== {6'd5, 6'd6}) begin
            errors++;
            $display("FAIL addr_out pe=5 got=%h exp=%h", res[5], {6'd5, 6'd6});
        end
        checks++;
        if (res[15] !== {6'd15, 6'd12}) begin
            errors++;
            $display("FAIL addr_out pe=15 got=%h exp=%h", res[15], {6'd15, 6'd12});
        end
`else
        checks++;
        if (res[5] !== {6'd0, 6'd6}) begin
            errors++;
            $display("FAIL addr_masked pe=5 got=%h exp=%h", res[5], {6'd0, 6'd6});
        end
`endif
    endtask

    task automatic test_hold();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                checks++;
                if (res[i] !== model(i)) begin
                    errors++;
                    $display("FAIL hold cycle=%0d pe=%0d got=%h exp=%h", k, i, res[i], model(i));
                end
            end
        end
    endtask

    // Asynchronous reset after done must clear outputs without waiting for a clock edge.
    task automatic test_reset_after_done();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res[i] !== '0) begin
                errors++;
                $display("FAIL async_clear pe=%0d got=%h exp=0", i, res[i]);
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res[i] !== '0) begin
                errors++;
                $display("FAIL mid_reset_zero pe=%0d got=%h exp=0", i, res[i]);
            end
        end
        repeat (2) @(posedge clk);
        test_sort("restart");
    endtask

    initial begin
        test_reset();
        test_sort("first");
        test_spot_values();
        test_hold();
        test_reset_after_done();
        test_mid_reset();
        test_spot_values();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesh_sort_demo.md
# mesh_sort_demo

Self-contained demonstration mesh of N processing elements (PEs) arranged SQRT_N × SQRT_N, row-major (PE i at row i/SQRT_N, column i%SQRT_N). After reset it loads a built-in reverse-permutation packet set and routes it with shearsort on the address field. Once sorting completes, every PE exposes the data of the packet addressed to it. Top-level block used for mesh bring-up and waveform debug.

## Interface
- N, 16: number of PEs; must equal SQRT_N².
- SQRT_N, 4: mesh side; power of two, ≥2.
- ADDR_WIDTH, 6: packet destination field width; 2^ADDR_WIDTH ≥ N.
- DATA_WIDTH, 6: packet payload width.
- SORT_CYCLES, 21: total cycles from load to done; must equal 1 + (2·log2(SQRT_N)+1)·SQRT_N.
- WIDTH: derived, ADDR_WIDTH+DATA_WIDTH.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- nanci_result  out  N × WIDTH (unpacked array, index = PE)  per-PE result.

## Operation
- Packet = {addr[ADDR_WIDTH-1:0], data[DATA_WIDTH-1:0]}; one packet register per PE.
- Load (cycle 0): PE j gets addr d = N-1-j, data = (3 + col(d) + 2·row(d)) mod 2^DATA_WIDTH.
- Shearsort, log2(SQRT_N) iterations of {row phase, column phase}, then one final row phase; each phase = SQRT_N odd-even transposition steps.
- Step s of a phase (s = 0..SQRT_N-1): s even compares pairs (2k, 2k+1), s odd compares (2k+1, 2k+2) along the line; all pairs in all lines update simultaneously.
- Iterated row phases: even rows ascending left→right, odd rows descending (snake). Column phases: ascending top→bottom. Final row phase: all rows ascending.
- Compare key = addr only; swap only if strictly out of order; the whole packet moves.
- Result: PE i holds addr i at done. nanci_result[i] = {ADDR_WIDTH'b0, data} of PE i's packet.
- Global step counter selects phase type and parity; counter saturates at done and the mesh freezes until next reset.

## Timing
- Reset asserted: all packet registers, counter, done and every nanci_result = 0.
- First rising edge after rst deasserts: load. Each following edge: one transposition step.
- done asserts internally after SORT_CYCLES edges; nanci_result valid from the same edge and held thereafter.
- Before done, nanci_result stays 0 (intermediate states never exposed).
- Reset mid-sort: immediate clear; the sequence restarts from load on release.
- No handshake, no inputs besides clk/rst.

## Configuration
- MESH_DB_ADDR_OUT_EN: when defined, nanci_result[i] carries the full packet {addr, data} (upper field = i at done). When undefined (default), the upper ADDR_WIDTH bits are forced 0.

## Test plan
- Defaults, rst low 2 cycles, release, wait ≥SORT_CYCLES+2 cycles -> nanci_result[0]=12'd3, [3]=12'd6, [12]=12'd9, [15]=12'd12.
- Same run, all PEs -> nanci_result[i] = 3 + i%4 + 2·(i/4) for every i; exactly SORT_CYCLES edges after release, not earlier.
- Sample during cycles 1..SORT_CYCLES-1 -> every nanci_result = 0.
- Assert rst mid-sort (cycle 10) asynchronously -> outputs 0 immediately; after release the same final values appear SORT_CYCLES edges later.
- MESH_DB_ADDR_OUT_EN defined -> nanci_result[5] = {6'd5, 6'd6}, nanci_result[15] = {6'd15, 6'd12}.
- Hold 200 cycles after done -> outputs unchanged.
